// File: rtl/pulse_train_gen.sv
// Bounce-free pulse train generator: emits req_count pulses of HIGH_CYCLES high /
// LOW_CYCLES low on a registered output, with abort and one-cycle done.
module pulse_train_gen #(
  parameter int HIGH_CYCLES = 1000,
  parameter int LOW_CYCLES  = 1000,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [COUNT_WIDTH-1:0] req_count,
  output logic                   req_ready,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   out
);

  localparam int MAXC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);

  localparam logic [TW-1:0]          H_LAST = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0]          L_LAST = TW'(LOW_CYCLES - 1);
  localparam logic [TW-1:0]          T_ONE  = TW'(1);
  localparam logic [COUNT_WIDTH-1:0] R_ONE  = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

  state_e                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [COUNT_WIDTH-1:0] rem_q,   rem_d;
  logic                   out_q,   out_d;
  logic                   done_q,  done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      rem_q   <= '0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  // Abort collapses the train into a single final low phase (remaining=1),
  // so the line always sees a full LOW_CYCLES low before the next request.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = HIGH;
            timer_d = '0;
            rem_d   = req_count;
          end
        end
      end
      HIGH: begin
        if (abort) begin
          state_d = LOW;
          timer_d = '0;
          rem_d   = R_ONE;
        end else if (timer_q == H_LAST) begin
          state_d = LOW;
          timer_d = '0;
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      LOW: begin
        if (abort) begin
          state_d = LOW;
          timer_d = '0;
          rem_d   = R_ONE;
        end else if (timer_q == L_LAST) begin
          timer_d = '0;
          if (rem_q <= R_ONE) begin
            state_d = IDLE;
            rem_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = HIGH;
            rem_d   = rem_q - R_ONE;
          end
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
        rem_d   = '0;
      end
    endcase
    out_d = (state_d == HIGH);
  end

  always_comb begin
    busy      = (state_q != IDLE);
    req_ready = (state_q == IDLE);
    out       = out_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench: per-cycle expected {out,busy,done,req_ready} pushed at
// stimulus time, popped and compared each cycle on the falling edge.
module tb_pulse_train_gen;

  localparam logic [3:0] E_HI = 4'b1100;
  localparam logic [3:0] E_LO = 4'b0100;
  localparam logic [3:0] E_DN = 4'b0011;
  localparam logic [3:0] E_ID = 4'b0001;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, abort;
  logic [7:0] req_count;
  logic       req_ready, busy, done, out;

  logic       v1, a1;
  logic [7:0] c1;
  logic       r1, b1, d1, o1;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  pulse_train_gen #(.HIGH_CYCLES(4), .LOW_CYCLES(3), .COUNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_count(req_count),
    .req_ready(req_ready), .abort(abort), .busy(busy), .done(done), .out(out));

  pulse_train_gen #(.HIGH_CYCLES(1), .LOW_CYCLES(1), .COUNT_WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_count(c1),
    .req_ready(r1), .abort(a1), .busy(b1), .done(d1), .out(o1));

  task automatic push(input logic [3:0] e, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic push_train(input int n);
    for (int p = 0; p < n; p++) begin
      push(E_HI, 4);
      push(E_LO, 3);
    end
    push(E_DN, 1);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_count = '0; abort = 1'b0;
    v1 = 1'b0; c1 = '0; a1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out, busy, done, req_ready} !== E_ID) begin
      errors++;
      $display("FAIL reset got %b exp %b", {out, busy, done, req_ready}, E_ID);
    end
    checks++;
    if ({o1, b1, d1, r1} !== E_ID) begin
      errors++;
      $display("FAIL reset_dut1 got %b exp %b", {o1, b1, d1, r1}, E_ID);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_two_pulses();
    logic [3:0] e;
    int cyc = 0;
    req_valid = 1'b1; req_count = 8'd2;
    push_train(2);
    while (exp_q.size() > 0) begin
      @(negedge clk); cyc++;
      e = exp_q.pop_front();
      checks++;
      if ({out, busy, done, req_ready} !== e) begin
        errors++;
        $display("FAIL two_pulses cyc %0d got %b exp %b", cyc, {out, busy, done, req_ready}, e);
      end
      if (cyc == 1) req_valid = 1'b0;
    end
  endtask

  task automatic test_zero_count();
    logic [3:0] e;
    int cyc = 0;
    req_valid = 1'b1; req_count = 8'd0;
    push(E_DN, 1);
    push(E_ID, 1);
    push_train(1);
    while (exp_q.size() > 0) begin
      @(negedge clk); cyc++;
      e = exp_q.pop_front();
      checks++;
      if ({out, busy, done, req_ready} !== e) begin
        errors++;
        $display("FAIL zero_count cyc %0d got %b exp %b", cyc, {out, busy, done, req_ready}, e);
      end
      if (cyc == 1) req_valid = 1'b0;
      if (cyc == 2) begin req_valid = 1'b1; req_count = 8'd1; end
      if (cyc == 3) req_valid = 1'b0;
    end
  endtask

  task automatic test_abort_idle();
    logic [3:0] e;
    int cyc = 0;
    req_valid = 1'b1; req_count = 8'd1; abort = 1'b1;
    push_train(1);
    while (exp_q.size() > 0) begin
      @(negedge clk); cyc++;
      e = exp_q.pop_front();
      checks++;
      if ({out, busy, done, req_ready} !== e) begin
        errors++;
        $display("FAIL abort_idle cyc %0d got %b exp %b", cyc, {out, busy, done, req_ready}, e);
      end
      if (cyc == 1) begin req_valid = 1'b0; abort = 1'b0; end
    end
  endtask

  task automatic test_abort();
    logic [3:0] e;
    logic prev = 1'b0;
    int cyc = 0, rises = 0, hi2 = 0;
    req_valid = 1'b1; req_count = 8'd3;
    push(E_HI, 4); push(E_LO, 3);
    push(E_HI, 2); push(E_LO, 3); push(E_DN, 1);
    while (exp_q.size() > 0) begin
      @(negedge clk); cyc++;
      e = exp_q.pop_front();
      checks++;
      if ({out, busy, done, req_ready} !== e) begin
        errors++;
        $display("FAIL abort cyc %0d got %b exp %b", cyc, {out, busy, done, req_ready}, e);
      end
      if (out && !prev) rises++;
      if (out && rises == 2) hi2++;
      prev = out;
      if (cyc == 1) req_valid = 1'b0;
      if (cyc == 9) abort = 1'b1;
      if (cyc == 10) abort = 1'b0;
    end
    checks++;
    if (rises !== 2) begin errors++; $display("FAIL abort_pulses got %0d exp 2", rises); end
    checks++;
    if (hi2 !== 2) begin errors++; $display("FAIL abort_trunc_high got %0d exp 2", hi2); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    logic prev = 1'b0;
    int cyc = 0, rises = 0, low_run = 0;
    req_valid = 1'b1; req_count = 8'd1;
    push_train(1);
    push_train(1);
    while (exp_q.size() > 0) begin
      @(negedge clk); cyc++;
      e = exp_q.pop_front();
      checks++;
      if ({out, busy, done, req_ready} !== e) begin
        errors++;
        $display("FAIL back_to_back cyc %0d got %b exp %b", cyc, {out, busy, done, req_ready}, e);
      end
      if (out && !prev) begin
        rises++;
        if (rises == 2) begin
          checks++;
          if (low_run !== 4) begin errors++; $display("FAIL b2b_gap got %0d exp 4", low_run); end
        end
      end
      low_run = out ? 0 : low_run + 1;
      prev = out;
      if (cyc == 16) req_valid = 1'b0;
    end
    checks++;
    if (rises !== 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", rises); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] e;
    int cyc = 0;
    req_valid = 1'b1; req_count = 8'd5;
    push(E_HI, 2);
    push(E_ID, 20);
    while (exp_q.size() > 0) begin
      @(negedge clk); cyc++;
      e = exp_q.pop_front();
      checks++;
      if ({out, busy, done, req_ready} !== e) begin
        errors++;
        $display("FAIL reset_mid cyc %0d got %b exp %b", cyc, {out, busy, done, req_ready}, e);
      end
      if (cyc == 1) req_valid = 1'b0;
      if (cyc == 2) rst = 1'b1;
      if (cyc == 3) rst = 1'b0;
    end
  endtask

  task automatic test_long();
    logic prev = 1'b0;
    int rises = 0, dones = 0, busy_cyc = 0, cyc = 0;
    v1 = 1'b1; c1 = 8'd255;
    while (cyc < 1000 && dones == 0) begin
      @(negedge clk); cyc++;
      if (cyc == 1) v1 = 1'b0;
      if (o1 && !prev) rises++;
      prev = o1;
      if (b1) busy_cyc++;
      if (d1) dones++;
    end
    repeat (5) begin
      @(negedge clk);
      if (d1) dones++;
      if (o1 && !prev) rises++;
      prev = o1;
    end
    checks++;
    if (rises !== 255) begin errors++; $display("FAIL long_rises got %0d exp 255", rises); end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL long_done got %0d exp 1", dones); end
    checks++;
    if (busy_cyc !== 510) begin errors++; $display("FAIL long_busy got %0d exp 510", busy_cyc); end
    checks++;
    if (dut1.rem_q !== 8'd0) begin errors++; $display("FAIL long_rem got %0d exp 0", dut1.rem_q); end
  endtask

  initial begin
    test_reset();
    test_two_pulses();
    test_zero_count();
    test_abort_idle();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_long();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
